// File: rtl/digit_display_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// digit_display_ctrl_pkg
// Shared glyph constants and BCD helpers used by the digit sequencer and by the
// digit renderer that lives in the parent design.
//   NUMBER_WIDTH / NUMBER_HEIGHT : glyph size drawn by the renderer
//   BLANK_CODE                   : code that makes the renderer draw nothing
// -----------------------------------------------------------------------------
package digit_display_ctrl_pkg;

    localparam int         NUMBER_WIDTH  = 60;
    localparam int         NUMBER_HEIGHT = 100;
    localparam logic [3:0] BLANK_CODE    = 4'hF;
    localparam logic [3:0] BCD_MAX       = 4'd9;

    // Next value of one decade, wrapping 9 -> 0.
    function automatic logic [3:0] bcd_next(input logic [3:0] d);
        return (d == BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/digit_display_ctrl_bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One decade of the ripple-carry BCD counter.
//   clk, rst   : pixel clock, synchronous active-high reset
//   inc_in     : increment request (external inc or carry from lower decade)
//   clr        : clear to 0, overrides inc_in
//   digit      : registered decade value 0..9
//   carry_out  : high when this decade wraps 9 -> 0 on the coming edge
// -----------------------------------------------------------------------------
module bcd_digit
    import digit_display_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_in,
    input  logic       clr,
    output logic [3:0] digit,
    output logic       carry_out
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    // Next decade value: clear beats increment.
    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = 4'd0;
        end else if (inc_in) begin
            digit_d = bcd_next(digit_q);
        end else begin
            digit_d = digit_q;
        end
    end

    // Decade register.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit     = digit_q;
    assign carry_out = inc_in & (digit_q == BCD_MAX);

endmodule

// File: rtl/digit_display_ctrl.sv
// -----------------------------------------------------------------------------
// digit_display_ctrl
// Sequences a row of decimal glyphs. Keeps a NUM_DIGITS BCD counter, snapshots
// it at frame start (x==0,y==0) so a frame never tears, decodes the active slot
// from the pixel position and registers the renderer's pixel.
// Ports:
//   clk, rst            : pixel clock, synchronous active-high reset
//   x, y, video_on      : VGA position and active-area flag
//   inc, clr            : single-cycle counter requests (clr wins)
//   pixel_in            : combinational pixel from the external renderer
//   number_code         : digit code to renderer (BLANK_CODE outside slots)
//   base_x, base_y      : slot origin to renderer
//   pixel_out           : registered glyph pixel (1 cycle latency)
//   overflow            : one-cycle pulse after the counter wraps
//   count               : live BCD counter, digit 0 in the MS nibble
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
// -----------------------------------------------------------------------------
module digit_display_ctrl
    import digit_display_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int ORIGIN_X    = 100,
    parameter int ORIGIN_Y    = 50,
    parameter int DIGIT_W     = 60,
    parameter int DIGIT_H     = 100,
    parameter int DIGIT_PITCH = 80
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [9:0]              x,
    input  logic [9:0]              y,
    input  logic                    video_on,
    input  logic                    inc,
    input  logic                    clr,
    input  logic                    pixel_in,
    output logic [3:0]              number_code,
    output logic [9:0]              base_x,
    output logic [9:0]              base_y,
    output logic                    pixel_out,
    output logic                    overflow,
    output logic [4*NUM_DIGITS-1:0] count
);

    localparam logic [9:0] ORG_X10 = 10'(ORIGIN_X);
    localparam logic [9:0] Y_TOP   = 10'(ORIGIN_Y);
    localparam logic [9:0] Y_BOT   = 10'(ORIGIN_Y + DIGIT_H);

    // Elaboration-time parameter sanity checks.
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num
        $error("digit_display_ctrl: NUM_DIGITS must be 1..8");
    end
    if (DIGIT_PITCH < DIGIT_W) begin : g_bad_pitch
        $error("digit_display_ctrl: DIGIT_PITCH must be >= DIGIT_W");
    end
    if (ORIGIN_X + (NUM_DIGITS - 1) * DIGIT_PITCH + DIGIT_W > 1023 ||
        ORIGIN_Y + DIGIT_H > 1023) begin : g_bad_edge
        $error("digit_display_ctrl: rightmost/bottom slot edge exceeds 1023");
    end
    if (DIGIT_W != NUMBER_WIDTH || DIGIT_H != NUMBER_HEIGHT) begin : g_bad_glyph
        $error("digit_display_ctrl: glyph size does not match renderer");
    end

    function automatic logic [9:0] slot_left(input int i);
        return 10'(ORIGIN_X + i * DIGIT_PITCH);
    endfunction

    function automatic logic [9:0] slot_right(input int i);
        return 10'(ORIGIN_X + i * DIGIT_PITCH + DIGIT_W);
    endfunction

    // ---------------------------------------------------------------- counter
    // carry_s[NUM_DIGITS] is the external inc into the LS decade; carry_s[0]
    // leaves the MS decade and marks a full wrap.
    logic [NUM_DIGITS:0] carry_s;
    assign carry_s[NUM_DIGITS] = inc;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk       (clk),
            .rst       (rst),
            .inc_in    (carry_s[i+1]),
            .clr       (clr),
            .digit     (count[4*(NUM_DIGITS-1-i) +: 4]),
            .carry_out (carry_s[i])
        );
    end

    // ------------------------------------------------------------- registers
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic                    pixel_q,  pixel_d;
    logic                    overflow_q, overflow_d;
    logic                    slot_active_s;

    // Shadow loads the pre-update counter at frame start.
    always_comb begin
        shadow_d = shadow_q;
        if (x == 10'd0 && y == 10'd0) begin
            shadow_d = count;
        end else begin
            shadow_d = shadow_q;
        end
    end

    // Next values of the pixel and overflow flags.
    always_comb begin
        pixel_d    = pixel_in & slot_active_s & video_on;
        overflow_d = carry_s[0] & ~clr;
    end

    // Shadow, pixel and overflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q   <= '0;
            pixel_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            pixel_q    <= pixel_d;
            overflow_q <= overflow_d;
        end
    end

    assign pixel_out = pixel_q;
    assign overflow  = overflow_q;

    // ------------------------------------------------------------ slot decode
    logic [NUM_DIGITS-1:0] blank_s;

`ifdef LEADING_ZERO_BLANK_EN
    logic lead_s;

    // A digit is blanked while it and everything above it are zero; the LS
    // digit is never blanked.
    always_comb begin
        lead_s  = 1'b1;
        blank_s = '0;
        for (int i = 0; i < NUM_DIGITS - 1; i++) begin
            lead_s     = lead_s & (shadow_q[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
            blank_s[i] = lead_s;
        end
    end
`else
    assign blank_s = '0;
`endif

    logic [NUM_DIGITS-1:0] hit_s;
    logic                  y_in_s;
    logic [3:0]            code_or_s;
    logic [9:0]            bx_or_s;

    // Per-slot range compare; slots never overlap so the selected code and
    // origin can be merged with a plain OR.
    always_comb begin
        y_in_s    = (y >= Y_TOP) && (y < Y_BOT);
        hit_s     = '0;
        code_or_s = 4'd0;
        bx_or_s   = 10'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            hit_s[i]  = y_in_s && (x >= slot_left(i)) && (x < slot_right(i))
                        && !blank_s[i];
            code_or_s = code_or_s | ({4{hit_s[i]}} & shadow_q[4*(NUM_DIGITS-1-i) +: 4]);
            bx_or_s   = bx_or_s | ({10{hit_s[i]}} & slot_left(i));
        end
    end

    // Renderer drive: blank code and slot 0 origin outside every slot.
    always_comb begin
        slot_active_s = |hit_s;
        base_y        = Y_TOP;
        if (slot_active_s) begin
            number_code = code_or_s;
            base_x      = bx_or_s;
        end else begin
            number_code = BLANK_CODE;
            base_x      = ORG_X10;
        end
    end

endmodule

// File: tb/tb_digit_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_digit_display_ctrl
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a decimal reference model of the counter, frame snapshot and slots.
// -----------------------------------------------------------------------------
module tb_digit_display_ctrl;

    localparam int N  = 4;
    localparam int OX = 100;
    localparam int OY = 50;
    localparam int W  = 60;
    localparam int H  = 100;
    localparam int P  = 80;

    logic           clk = 1'b0;
    logic           rst, video_on, inc, clr, pixel_in;
    logic [9:0]     x, y;
    logic [3:0]     number_code;
    logic [9:0]     base_x, base_y;
    logic           pixel_out, overflow;
    logic [4*N-1:0] count;

    always #5 clk = ~clk;

    digit_display_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .x           (x),
        .y           (y),
        .video_on    (video_on),
        .inc         (inc),
        .clr         (clr),
        .pixel_in    (pixel_in),
        .number_code (number_code),
        .base_x      (base_x),
        .base_y      (base_y),
        .pixel_out   (pixel_out),
        .overflow    (overflow),
        .count       (count)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state (plain decimal integers).
    int cnt_m = 0;
    int sh_m  = 0;
    bit ovf_m = 1'b0;
    bit pix_m = 1'b0;
    bit armed = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int pow10(input int e);
        int r = 1;
        for (int k = 0; k < e; k++) r = r * 10;
        return r;
    endfunction

    function automatic int digit_of(input int v, input int i);
        return (v / pow10(N - 1 - i)) % 10;
    endfunction

    function automatic logic [4*N-1:0] to_bcd(input int v);
        logic [4*N-1:0] r = '0;
        for (int i = 0; i < N; i++) r[4*(N-1-i) +: 4] = 4'(digit_of(v, i));
        return r;
    endfunction

    // Slot index under (xx,yy) for displayed value sh, or -1 when none.
    function automatic int slot_of(input int xx, input int yy, input int sh);
        int s;
        if (yy < OY || yy >= OY + H || xx < OX) return -1;
        s = (xx - OX) / P;
        if (s >= N || (xx - OX) % P >= W) return -1;
`ifdef LEADING_ZERO_BLANK_EN
        if (s < N - 1 && sh < pow10(N - 1 - s)) return -1;
`endif
        return s;
    endfunction

    // One clock: drive, check combinational outputs, clock, check registers.
    task automatic cycle(input int xx, input int yy, input bit vo, input bit i_inc,
                         input bit i_clr, input bit pin, input bit i_rst);
        int s;
        x = 10'(xx); y = 10'(yy); video_on = vo; inc = i_inc; clr = i_clr;
        pixel_in = pin; rst = i_rst;
        #1;
        s = slot_of(xx, yy, sh_m);
        if (armed) begin
            check_eq("number_code", 32'(number_code), (s < 0) ? 32'hF : 32'(digit_of(sh_m, s)));
            check_eq("base_x", 32'(base_x), (s < 0) ? 32'(OX) : 32'(OX + s * P));
            check_eq("base_y", 32'(base_y), 32'(OY));
        end
        @(posedge clk);
        if (i_rst) begin
            cnt_m = 0; sh_m = 0; ovf_m = 1'b0; pix_m = 1'b0;
        end else begin
            pix_m = pin && vo && (s >= 0);
            if (xx == 0 && yy == 0) sh_m = cnt_m;
            ovf_m = 1'b0;
            if (i_clr) begin
                cnt_m = 0;
            end else if (i_inc) begin
                if (cnt_m == pow10(N) - 1) begin
                    cnt_m = 0; ovf_m = 1'b1;
                end else begin
                    cnt_m = cnt_m + 1;
                end
            end
        end
        #1;
        armed = 1'b1;
        check_eq("count", 32'(count), 32'(to_bcd(cnt_m)));
        check_eq("overflow", 32'(overflow), 32'(ovf_m));
        check_eq("pixel_out", 32'(pixel_out), 32'(pix_m));
    endtask

    // Background cycle away from frame start (y never 0).
    task automatic idle_inc(input bit i_inc);
        cycle($urandom_range(0, 1023), $urandom_range(1, 1023), 1'($urandom_range(0, 1)),
              i_inc, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic scan_slots();
        for (int s = 0; s < N; s++) cycle(OX + s * P + 10, 80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        x = 10'd5; y = 10'd5; video_on = 1'b0; inc = 1'b0; clr = 1'b0;
        pixel_in = 1'b0; rst = 1'b1;
        cycle(5, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(5, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Slot 0 after reset, pixel_in rising shows up a cycle later.
        cycle(130, 80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(130, 80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(130, 80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // 1234 increments, frame start, then slot scan.
        for (int k = 0; k < 1234; k++) idle_inc(1'b1);
        cycle(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        scan_slots();

        // Gap pixel and video_on low.
        cycle(165, 80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(130, 80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(130, 80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Mid-frame increment holds the displayed value until frame start.
        cycle(300, 200, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        scan_slots();
        cycle(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        scan_slots();

        // Full wrap with overflow pulse.
        cycle(7, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 9999; k++) idle_inc(1'b1);
        idle_inc(1'b1);
        idle_inc(1'b0);
        idle_inc(1'b0);

        // inc and clr together at 9998.
        for (int k = 0; k < 9998; k++) idle_inc(1'b1);
        cycle(9, 9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle_inc(1'b0);

        // Small value, useful for leading-zero blanking.
        for (int k = 0; k < 7; k++) idle_inc(1'b1);
        cycle(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        scan_slots();
        cycle(3, 3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        scan_slots();

        // Randomized traffic, biased into the slot area.
        for (int k = 0; k < 3000; k++) begin
            int xx, yy, r;
            r = $urandom_range(0, 99);
            if (r < 5) begin
                xx = 0; yy = 0;
            end else if (r < 70) begin
                xx = $urandom_range(90, 430); yy = $urandom_range(40, 160);
            end else begin
                xx = $urandom_range(0, 1023); yy = $urandom_range(0, 1023);
            end
            cycle(xx, yy, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 199) == 0));
        end

        // Mid-frame reset: display returns to 0 immediately.
        cycle(11, 300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        scan_slots();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/digit_display_ctrl.md
Name: digit_display_ctrl

Overview:
Sequences a row of decimal digit glyphs on the VGA screen. Keeps a NUM_DIGITS-wide BCD counter driven by inc/clr pulses. Snapshots the counter once per frame so the displayed value never tears mid-frame. For each pixel coordinate it selects the active digit slot, drives the existing combinational digit renderer (code plus base position), and registers the returned pixel for the colour mux.

Parameters:
NUM_DIGITS, 4, number of digit slots and BCD counter width in digits (1..8)
ORIGIN_X, 100, X of the left edge of slot 0 (most significant digit)
ORIGIN_Y, 50, Y of the top edge of all slots
DIGIT_W, 60, glyph width; must match the renderer
DIGIT_H, 100, glyph height; must match the renderer
DIGIT_PITCH, 80, X distance between slot left edges; must be >= DIGIT_W

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous, active-high reset
x  in  10  current VGA column
y  in  10  current VGA row
video_on  in  1  high in the active display area
inc  in  1  single-cycle increment request
clr  in  1  single-cycle clear request
pixel_in  in  1  renderer pixel output, combinational from number_code/base_x/base_y/x/y
number_code  out  4  digit code to renderer; 4'hF when outside every slot
base_x  out  10  slot X origin to renderer
base_y  out  10  slot Y origin to renderer
pixel_out  out  1  registered glyph pixel
overflow  out  1  one-cycle pulse on counter wrap
count  out  4*NUM_DIGITS  live BCD counter; digit 0 in the MS nibble

Behaviour:
- Reset (rst high at a clk edge): counter = 0, shadow = 0, pixel_out = 0, overflow = 0. Combinational outputs follow from shadow = 0.
- Counter: BCD ripple carry.
  - clr has priority over inc: clr -> counter 0, no overflow pulse.
  - inc alone -> counter + 1, taking effect on the next edge.
  - All-9s + inc -> all-0s, with overflow high for exactly that one following cycle.
  - inc and clr together -> counter 0, overflow 0.
- Shadow: loads the counter (pre-update value of that cycle) when x == 0 && y == 0. Otherwise it holds.
- Slot decode (combinational, no divider):
  - Slot i is active when ORIGIN_X + i*DIGIT_PITCH <= x < ORIGIN_X + i*DIGIT_PITCH + DIGIT_W and ORIGIN_Y <= y < ORIGIN_Y + DIGIT_H.
  - Active slot: number_code = shadow digit i, base_x = ORIGIN_X + i*DIGIT_PITCH, base_y = ORIGIN_Y.
  - No active slot: number_code = 4'hF, base_x = ORIGIN_X, base_y = ORIGIN_Y.
  - Slots never overlap, because DIGIT_PITCH >= DIGIT_W.
- Pixel: pixel_out <= pixel_in & slot_active & video_on. Latency is one clk; the colour mux delays syncs to match.
- Widths: all position arithmetic is 10-bit unsigned. Parameters must keep the rightmost slot edge <= 1023; this is checked by a synthesis-time assertion.
- rst asserted mid-frame: the display shows 0 from the next cycle, with no wait for frame start.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: a shadow digit i < NUM_DIGITS-1 that is 0 while every more-significant digit is also 0 forces number_code = 4'hF and slot_active = 0. The least significant digit is always drawn.
- Undefined: all digits are drawn, including leading zeros.

Decomposition:
- Shared package/header holds NUMBER_HEIGHT/NUMBER_WIDTH glyph constants and the BLANK_CODE = 4'hF constant. The renderer and this block both use them.
- Sub-module bcd_digit: one 4-bit decade with inc_in, clr, carry_out. It is instantiated NUM_DIGITS times in a generate loop.
- The renderer is instantiated by the parent, not inside this block.

Test Plan:
- Reset, then scan pixel (130,80) (slot 0 at defaults) -> number_code 0, base_x 100, base_y 50. Reset alone gives pixel_out 0 until pixel_in rises, which appears one cycle later.
- 1234 inc pulses, then a frame-start pixel (0,0) -> count 16'h1234, slot codes 1,2,3,4, base_x 100/180/260/340.
- Load 9999, then inc -> count 0000 and overflow high for exactly 1 cycle; with inc+clr together at 9998 -> 0000, overflow 0.
- inc mid-frame (y = 200) -> number_code for slot pixels unchanged until the next (0,0), then updated.
- Pixel (165,80) in the gap between slots 0 and 1 -> number_code F, pixel_out 0 even if pixel_in forced to 1. With video_on = 0 -> pixel_out 0.
- With LEADING_ZERO_BLANK_EN and value 0007 -> slots 0-2 code F, slot 3 code 7. With value 0000 -> only slot 3 drawn (code 0).
